updown_accumulator: RTL and testbench

Parametrised signed up/down accumulator for the ADPLL loop filter and phase-error integration path. It generalises the single-step saturating counter in four ways: programmable step magnitude, selectable saturate or wrap mode, synchronous load, and registered saturation and overflow status. In saturate mode the count can leave a rail again; it does not lock at the limit. It sits between the phase detector's up/down instruction and the DCO tuning word.

---
 rtl/updown_pkg.sv | 18 +
 rtl/updown_accumulator_if.sv | 36 +++
 rtl/updown_sat_add.sv | 43 ++++
 rtl/updown_accumulator.sv | 104 ++++++++++
 tb/tb_updown_accumulator.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/updown_pkg.sv
// Shared instruction encodings and symmetric limit helpers for the up/down accumulator.
package updown_pkg;

  localparam logic [1:0] DISABLE    = 2'b00;
  localparam logic [1:0] COUNT_UP   = 2'b01;
  localparam logic [1:0] COUNT_DOWN = 2'b10;
  localparam logic [1:0] HOLD       = 2'b11;

  function automatic longint max_val(int unsigned width);
    return (longint'(1) <<< (width - 1)) - longint'(1);
  endfunction

  // Symmetric range: the most negative two's-complement code is excluded.
  function automatic longint min_val(int unsigned width);
    return -max_val(width);
  endfunction

endpackage

// File: rtl/updown_accumulator_if.sv
// Control and status bundle for updown_accumulator.
// ovf_cnt_o exists only when UDACC_OVF_CNT_EN is defined.
interface updown_accumulator_if #(
  parameter int unsigned WIDTH  = 20,
  parameter int unsigned STEP_W = 8
);
  logic                    clear_i;
  logic                    load_i;
  logic signed [WIDTH-1:0] load_val_i;
  logic [1:0]              count_instr_i;
  logic [STEP_W-1:0]       step_i;
  logic signed [WIDTH-1:0] count_val_o;
  logic                    sat_hi_o;
  logic                    sat_lo_o;
  logic                    ovf_pulse_o;
`ifdef UDACC_OVF_CNT_EN
  logic [7:0]              ovf_cnt_o;
`endif

  modport master (
    output clear_i, load_i, load_val_i, count_instr_i, step_i,
    input  count_val_o, sat_hi_o, sat_lo_o, ovf_pulse_o
`ifdef UDACC_OVF_CNT_EN
    , input ovf_cnt_o
`endif
  );

  modport slave (
    input  clear_i, load_i, load_val_i, count_instr_i, step_i,
    output count_val_o, sat_hi_o, sat_lo_o, ovf_pulse_o
`ifdef UDACC_OVF_CNT_EN
    , output ovf_cnt_o
`endif
  );

endinterface

// File: rtl/updown_sat_add.sv
// Combinational (WIDTH+1)-bit add/subtract of an unsigned step, with symmetric
// clamping (WRAP_MODE=0) or modulo-2^WIDTH wrap (WRAP_MODE=1) and an overflow flag.
module updown_sat_add
  import updown_pkg::*;
#(
  parameter int unsigned WIDTH     = 20,
  parameter int unsigned STEP_W    = 8,
  parameter int unsigned WRAP_MODE = 0
) (
  input  logic signed [WIDTH-1:0] count_i,
  input  logic [STEP_W-1:0]       step_i,
  input  logic                    up_i,
  output logic signed [WIDTH-1:0] next_o,
  output logic                    ovf_o
);

  localparam logic signed [WIDTH:0] MaxVal = (WIDTH + 1)'(max_val(WIDTH));
  localparam logic signed [WIDTH:0] MinVal = (WIDTH + 1)'(min_val(WIDTH));

  logic signed [WIDTH:0] count_ext;
  logic signed [WIDTH:0] step_ext;
  logic signed [WIDTH:0] sum;

  assign count_ext = {count_i[WIDTH-1], count_i};
  assign step_ext  = {{(WIDTH + 1 - STEP_W){1'b0}}, step_i};
  assign sum       = up_i ? (count_ext + step_ext) : (count_ext - step_ext);

  always_comb begin
    next_o = sum[WIDTH-1:0];
    ovf_o  = 1'b0;
    if (WRAP_MODE != 0) begin
      // Signed overflow shows up as disagreement between the guard and sign bits.
      ovf_o = sum[WIDTH] ^ sum[WIDTH-1];
    end else if (sum > MaxVal) begin
      next_o = MaxVal[WIDTH-1:0];
      ovf_o  = 1'b1;
    end else if (sum < MinVal) begin
      next_o = MinVal[WIDTH-1:0];
      ovf_o  = 1'b1;
    end
  end

endmodule

// File: rtl/updown_accumulator.sv
// Signed up/down accumulator for the ADPLL loop filter: clear > load > count priority,
// registered rail flags and overflow pulse. Define UDACC_OVF_CNT_EN for ovf_cnt_o.
module updown_accumulator
  import updown_pkg::*;
#(
  parameter int unsigned WIDTH     = 20,
  parameter int unsigned STEP_W    = 8,
  parameter int unsigned WRAP_MODE = 0
) (
  input logic                 fpga_clk_i,
  input logic                 reset_n_i,
  updown_accumulator_if.slave bus
);

  localparam logic signed [WIDTH-1:0] MaxVal = WIDTH'(max_val(WIDTH));
  localparam logic signed [WIDTH-1:0] MinVal = WIDTH'(min_val(WIDTH));

  logic signed [WIDTH-1:0] count_q, count_d;
  logic signed [WIDTH-1:0] add_next;
  logic                    add_ovf;
  logic                    ovf_q, ovf_d;
  logic                    sat_hi_q, sat_hi_d;
  logic                    sat_lo_q, sat_lo_d;

  updown_sat_add #(
    .WIDTH     (WIDTH),
    .STEP_W    (STEP_W),
    .WRAP_MODE (WRAP_MODE)
  ) u_sat_add (
    .count_i (count_q),
    .step_i  (bus.step_i),
    .up_i    (bus.count_instr_i == COUNT_UP),
    .next_o  (add_next),
    .ovf_o   (add_ovf)
  );

  always_comb begin
    count_d = count_q;
    ovf_d   = 1'b0;
    if (bus.clear_i) begin
      count_d = '0;
    end else if (bus.load_i) begin
      count_d = bus.load_val_i;
      // Only the most negative code lies outside the symmetric range.
      if ((WRAP_MODE == 0) && (bus.load_val_i < MinVal)) begin
        count_d = MinVal;
      end
    end else begin
      unique case (bus.count_instr_i)
        COUNT_UP, COUNT_DOWN: begin
          count_d = add_next;
          ovf_d   = add_ovf;
        end
        DISABLE, HOLD: ;
        default: ;
      endcase
    end
    sat_hi_d = (WRAP_MODE == 0) && (count_d == MaxVal);
    sat_lo_d = (WRAP_MODE == 0) && (count_d == MinVal);
  end

  always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_q  <= '0;
      ovf_q    <= 1'b0;
      sat_hi_q <= 1'b0;
      sat_lo_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      sat_hi_q <= sat_hi_d;
      sat_lo_q <= sat_lo_d;
    end
  end

  assign bus.count_val_o = count_q;
  assign bus.ovf_pulse_o = ovf_q;
  assign bus.sat_hi_o    = sat_hi_q;
  assign bus.sat_lo_o    = sat_lo_q;

`ifdef UDACC_OVF_CNT_EN
  logic [7:0] ovf_cnt_q, ovf_cnt_d;

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (bus.clear_i) begin
      ovf_cnt_d = '0;
    end else if (ovf_d && (ovf_cnt_q != 8'hff)) begin
      ovf_cnt_d = ovf_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ovf_cnt_q <= '0;
    end else begin
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  assign bus.ovf_cnt_o = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_updown_accumulator.sv
// Bench for updown_accumulator: one saturating and one wrapping instance share stimulus;
// an integer model is compared every cycle, with literal spot checks alongside.
module tb_updown_accumulator;

  localparam int W    = 8;
  localparam int SW   = 4;
  localparam int MAXV = 127;
  localparam int MINV = -127;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       clear = 1'b0;
  logic       load  = 1'b0;
  logic [7:0] load_val = '0;
  logic [1:0] instr = 2'b00;
  logic [3:0] step  = '0;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  updown_accumulator_if #(.WIDTH(W), .STEP_W(SW)) bus_s ();
  updown_accumulator_if #(.WIDTH(W), .STEP_W(SW)) bus_w ();

  assign bus_s.clear_i       = clear;
  assign bus_s.load_i        = load;
  assign bus_s.load_val_i    = load_val;
  assign bus_s.count_instr_i = instr;
  assign bus_s.step_i        = step;
  assign bus_w.clear_i       = clear;
  assign bus_w.load_i        = load;
  assign bus_w.load_val_i    = load_val;
  assign bus_w.count_instr_i = instr;
  assign bus_w.step_i        = step;

  updown_accumulator #(.WIDTH(W), .STEP_W(SW), .WRAP_MODE(0)) dut_s (
    .fpga_clk_i (clk),
    .reset_n_i  (rst_n),
    .bus        (bus_s)
  );

  updown_accumulator #(.WIDTH(W), .STEP_W(SW), .WRAP_MODE(1)) dut_w (
    .fpga_clk_i (clk),
    .reset_n_i  (rst_n),
    .bus        (bus_w)
  );

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: index 0 = saturate, 1 = wrap.
  int m_cnt[2]   = '{0, 0};
  int m_pulse[2] = '{0, 0};
  int m_ocnt[2]  = '{0, 0};

  function automatic void model_next(input int cnt, input bit wrap, output int nc, output int p);
    p  = 0;
    nc = cnt;
    if (clear) begin
      nc = 0;
    end else if (load) begin
      nc = int'($signed(load_val));
      if (!wrap && nc < MINV) nc = MINV;
    end else if (instr == 2'b01 || instr == 2'b10) begin
      nc = (instr == 2'b01) ? cnt + int'(step) : cnt - int'(step);
      if (!wrap) begin
        if (nc > MAXV) begin nc = MAXV; p = 1; end
        else if (nc < MINV) begin nc = MINV; p = 1; end
      end else begin
        if (nc > MAXV) begin nc = nc - 256; p = 1; end
        else if (nc < -128) begin nc = nc + 256; p = 1; end
      end
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_cnt[k]   <= 0;
        m_pulse[k] <= 0;
        m_ocnt[k]  <= 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        int nc;
        int p;
        model_next(m_cnt[k], (k == 1), nc, p);
        m_cnt[k]   <= nc;
        m_pulse[k] <= p;
        if (clear) m_ocnt[k] <= 0;
        else if (p != 0 && m_ocnt[k] < 255) m_ocnt[k] <= m_ocnt[k] + 1;
      end
    end
  end

  always @(negedge clk) begin
    check("s_count", int'($signed(bus_s.count_val_o)), m_cnt[0]);
    check("s_pulse", int'(bus_s.ovf_pulse_o), m_pulse[0]);
    check("s_sat_hi", int'(bus_s.sat_hi_o), int'(m_cnt[0] == MAXV));
    check("s_sat_lo", int'(bus_s.sat_lo_o), int'(m_cnt[0] == MINV));
    check("w_count", int'($signed(bus_w.count_val_o)), m_cnt[1]);
    check("w_pulse", int'(bus_w.ovf_pulse_o), m_pulse[1]);
    check("w_sat_hi", int'(bus_w.sat_hi_o), 0);
    check("w_sat_lo", int'(bus_w.sat_lo_o), 0);
`ifdef UDACC_OVF_CNT_EN
    check("s_ovf_cnt", int'(bus_s.ovf_cnt_o), m_ocnt[0]);
    check("w_ovf_cnt", int'(bus_w.ovf_cnt_o), m_ocnt[1]);
`endif
  end

  task automatic cyc(input logic c, input logic l, input int lv, input logic [1:0] ins,
                     input int st);
    logic [31:0] lv_bits;
    logic [31:0] st_bits;
    lv_bits  = lv;
    st_bits  = st;
    clear    = c;
    load     = l;
    load_val = lv_bits[7:0];
    instr    = ins;
    step     = st_bits[3:0];
    @(posedge clk);
    #1;
  endtask

  function automatic int sc();
    return int'($signed(bus_s.count_val_o));
  endfunction

  function automatic int wc();
    return int'($signed(bus_w.count_val_o));
  endfunction

  initial begin
    #1 rst_n = 1'b0;
    #2;
    check("reset_count", sc(), 0);
    check("reset_pulse", int'(bus_s.ovf_pulse_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: asynchronous reset mid-operation
    cyc(1'b0, 1'b1, 30, 2'b00, 0);
    cyc(1'b0, 1'b0, 0, 2'b01, 7);
    check("t1_count37", sc(), 37);
    #2 rst_n = 1'b0;
    #1;
    check("t1_async_count", sc(), 0);
    check("t1_async_flags", int'({bus_s.sat_hi_o, bus_s.sat_lo_o, bus_s.ovf_pulse_o}), 0);
    @(posedge clk);
    #1;
    check("t1_held_count", sc(), 0);
    instr = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 2: upper rail in saturate mode
    cyc(1'b0, 1'b1, 120, 2'b00, 0);
    cyc(1'b0, 1'b0, 0, 2'b01, 5);
    check("t2_125", sc(), 125);
    cyc(1'b0, 1'b0, 0, 2'b01, 5);
    check("t2_127", sc(), 127);
    check("t2_pulse", int'(bus_s.ovf_pulse_o), 1);
    check("t2_sat_hi", int'(bus_s.sat_hi_o), 1);
    cyc(1'b0, 1'b0, 0, 2'b01, 0);
    check("t2_step0_pulse", int'(bus_s.ovf_pulse_o), 0);
    cyc(1'b0, 1'b0, 0, 2'b10, 1);
    check("t2_126", sc(), 126);
    check("t2_sat_hi_off", int'(bus_s.sat_hi_o), 0);

    // 3: lower rail and clamped load
    cyc(1'b0, 1'b1, -125, 2'b00, 0);
    cyc(1'b0, 1'b0, 0, 2'b10, 3);
    check("t3_m127", sc(), -127);
    check("t3_pulse", int'(bus_s.ovf_pulse_o), 1);
    check("t3_sat_lo", int'(bus_s.sat_lo_o), 1);
    cyc(1'b0, 1'b1, -128, 2'b00, 0);
    check("t3_load_clamp", sc(), -127);
    check("t3_load_nopulse", int'(bus_s.ovf_pulse_o), 0);
    check("t3_wrap_load", wc(), -128);

    // 4: wrap mode
    cyc(1'b0, 1'b1, 126, 2'b00, 0);
    cyc(1'b0, 1'b0, 0, 2'b01, 3);
    check("t4_wrap", wc(), -127);
    check("t4_wrap_pulse", int'(bus_w.ovf_pulse_o), 1);
    check("t4_wrap_flags", int'({bus_w.sat_hi_o, bus_w.sat_lo_o}), 0);
    cyc(1'b0, 1'b0, 0, 2'b01, 0);
    check("t4_step0", wc(), -127);
    check("t4_step0_pulse", int'(bus_w.ovf_pulse_o), 0);

    // 5: priority and hold
    cyc(1'b0, 1'b1, 40, 2'b00, 0);
    cyc(1'b1, 1'b1, 90, 2'b01, 5);
    check("t5_clear_wins", sc(), 0);
    cyc(1'b0, 1'b1, 50, 2'b01, 5);
    check("t5_load_wins", sc(), 50);
    cyc(1'b0, 1'b0, 0, 2'b11, 5);
    check("t5_hold", sc(), 50);
    cyc(1'b0, 1'b0, 0, 2'b00, 5);
    check("t5_disable", wc(), 50);

`ifdef UDACC_OVF_CNT_EN
    // 6: overflow event counter saturates at 255
    cyc(1'b1, 1'b0, 0, 2'b00, 0);
    cyc(1'b0, 1'b1, 127, 2'b00, 0);
    for (int i = 0; i < 300; i++) cyc(1'b0, 1'b0, 0, 2'b01, 1);
    check("t6_ovf_cnt_255", int'(bus_s.ovf_cnt_o), 255);
    cyc(1'b0, 1'b1, 10, 2'b00, 0);
    check("t6_load_keeps", int'(bus_s.ovf_cnt_o), 255);
    cyc(1'b1, 1'b0, 0, 2'b00, 0);
    check("t6_clear", int'(bus_s.ovf_cnt_o), 0);
`endif

    cyc(1'b0, 1'b0, 0, 2'b00, 0);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
